// File: rtl/sad_min_tracker.sv
// sad_min_tracker
// Scans one WIN_ROWS x WIN_COLS search window of candidate SADs. It keeps the
// running minimum and its (row, col) position, pulses oRegWrite2Sum for one
// cycle after every improvement, and holds oDone once the window is finished.
//
// Optional build macro: SAD_EARLY_EXIT_EN
//   Defined   -> adds the iThreshold input. An accepted candidate with
//                iSAD <= iThreshold ends the scan early.
//   Undefined -> the full window is always scanned.
//
// Handshake: there is no back-pressure. A candidate is consumed on any
// rising edge where state is SCAN, iValid=1, iStart=0 and Rst=1. Results
// become visible one cycle later. iStart wins over iValid in the same cycle.
//
// dbg_state exposes the FSM encoding (0=IDLE, 1=SCAN, 2=DONE) so that
// checkers can bind to it.

module sad_min_tracker #(
  parameter int          SAD_WIDTH = 32,
  parameter int          WIN_ROWS  = 16,
  parameter int          WIN_COLS  = 16,
  parameter int unsigned INIT_MIN  = 50000,
  parameter bit          TIE_LAST  = 1'b1,
  localparam int         RW        = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1,
  localparam int         CW        = (WIN_COLS > 1) ? $clog2(WIN_COLS) : 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 iStart,
  input  logic                 iValid,
  input  logic [SAD_WIDTH-1:0] iSAD,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [SAD_WIDTH-1:0] iThreshold,
`endif
  output logic [SAD_WIDTH-1:0] oMinSAD,
  output logic [RW-1:0]        oBestRow,
  output logic [CW-1:0]        oBestCol,
  output logic                 oRegWrite2Sum,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [1:0]           dbg_state
);

  localparam logic [SAD_WIDTH-1:0] INIT_VAL = SAD_WIDTH'(INIT_MIN);
  localparam logic [RW-1:0]        ROW_LAST = RW'(WIN_ROWS - 1);
  localparam logic [CW-1:0]        COL_LAST = CW'(WIN_COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [RW-1:0]   row_cnt;
  logic [CW-1:0]   col_cnt;

  logic            accept;
  logic            at_last;
  logic            le_min;
  logic            lt_min;
  logic            upd_base;
  logic            do_update;
  logic            early_exit;
  logic            finish_scan;

  // Candidate qualification, compare and window-end detection.
  always_comb begin
    accept   = (state == ST_SCAN) && iValid && !iStart;
    at_last  = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    le_min   = (iSAD <= oMinSAD);
    lt_min   = (iSAD <  oMinSAD);
    upd_base = TIE_LAST ? le_min : lt_min;
`ifdef SAD_EARLY_EXIT_EN
    // A candidate at or below the threshold is good enough: it ends the scan.
    // It also takes the minimum on equality regardless of tie mode.
    early_exit = (iSAD <= iThreshold);
    do_update  = early_exit ? le_min : upd_base;
`else
    early_exit = 1'b0;
    do_update  = upd_base;
`endif
    finish_scan = accept && (at_last || early_exit);
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic. iStart restarts from any state.
  always_comb begin
    state_nxt = state;
    if (iStart) begin
      state_nxt = ST_SCAN;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_SCAN: if (finish_scan) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM-decoded status outputs.
  always_comb begin
    oBusy     = (state == ST_SCAN);
    oDone     = (state == ST_DONE);
    dbg_state = state;
  end

  // Running minimum, best position, raster counters and the write pulse.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      oMinSAD       <= INIT_VAL;
      oBestRow      <= '0;
      oBestCol      <= '0;
      row_cnt       <= '0;
      col_cnt       <= '0;
      oRegWrite2Sum <= 1'b0;
    end else begin
      oRegWrite2Sum <= 1'b0;
      if (iStart) begin
        oMinSAD  <= INIT_VAL;
        oBestRow <= '0;
        oBestCol <= '0;
        row_cnt  <= '0;
        col_cnt  <= '0;
      end else if (accept) begin
        if (do_update) begin
          oMinSAD       <= iSAD;
          oBestRow      <= row_cnt;
          oBestCol      <= col_cnt;
          oRegWrite2Sum <= 1'b1;
        end
        // Counters return to the origin when the scan ends so the next
        // window starts clean even before iStart clears them.
        if (at_last || early_exit) begin
          row_cnt <= '0;
          col_cnt <= '0;
        end else if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

endmodule
